pool: RTL
=========

// Module: pool
// PURPOSE
//  Pooling stage directly downstream of the normalization stage; consumes its column stream
//  (one DESIGN_SIZE-lane column of signed Q4.3 values per valid cycle) and emits k x k
//  max- or average-pooled columns to the activation stage. One tile = DESIGN_SIZE columns.
//  Window k is taken across k adjacent lanes and k consecutive columns.
// PARAMETERS
//  DWIDTH         8   element width, signed Q4.3
//  DESIGN_SIZE    32  lanes per column and columns per tile; must be a multiple of 4
//  MAX_BITS_POOL  3   width of pool_window_size
//  ACC_WIDTH      12  signed accumulator width for average mode (holds 16 x DWIDTH sum)
// PORTS
//  clk                 in   1                    clock, rising edge
//  reset_n             in   1                    asynchronous, active-low reset
//  enable_pool         in   1                    1 = pool, 0 = registered bypass
//  pool_mode           in   1                    0 = max, 1 = average
//  pool_window_size    in   MAX_BITS_POOL        k; 1, 2, 4 legal, any other value acts as 1
//  in_data_available   in   1                    inp_data valid this cycle
//  inp_data            in   DESIGN_SIZE*DWIDTH   lane i at [i*DWIDTH +: DWIDTH]
//  validity_mask       in   DESIGN_SIZE          1 = lane i holds real data
//  out_data            out  DESIGN_SIZE*DWIDTH   pooled column
//  out_data_available  out  1                    out_data valid, single-cycle pulse per column
//  done_pool           out  1                    tile complete
// BEHAVIOUR
//  Reset (reset_n low, async): all registers 0; out_data=0, out_data_available=0, done_pool=0.
//  Bypass (enable_pool=0): out_data/out_data_available = inp_data/in_data_available delayed by
//   exactly 1 cycle; done_pool=1; internal counters/accumulators held at 0.
//  k and pool_mode are latched at the first accepted column of a tile; changes mid-tile ignored.
//  A column is accepted on each rising edge with in_data_available=1; gaps allowed, the counters
//   advance only on accepted columns.
//  Stage 1 (accept edge): per group g in 0..DESIGN_SIZE/k-1, reduce lanes g*k..g*k+k-1:
//   max: signed max, masked lanes treated as -128; avg: signed sum, masked lanes contribute 0.
//  Stage 2: fold stage-1 result into per-group accumulator; first column of a window loads,
//   others combine (max or add). Column counter within window counts 0..k-1, wraps to 0.
//  Output: on the edge after the k-th column of a window reaches stage 2, out_data is registered
//   and out_data_available pulses high for 1 cycle. Latency: 2 edges from accept edge of the
//   window's last column to out_data_available high.
//  Output packing: group g in lane g; lanes >= DESIGN_SIZE/k driven 0. DESIGN_SIZE/k output
//   columns per tile.
//  Average: result = (sum + 2^(s-1)) >>> s, s=2*log2(k) (k=1: s=0, no rounding); arithmetic
//   shift, rounds half toward +inf; result always fits DWIDTH, no saturation needed.
//   Divisor is k*k regardless of mask (masked lanes count as 0).
//  k=1: each column passes through the pipeline unchanged except masked lanes: max-> -128
//   (8'h80), avg-> 0; output latency 2 edges.
//  done_pool: set on the edge the tile's last output column is registered (same cycle as the final
//   out_data_available); sticky until enable_pool=0 or reset. Columns arriving while done_pool=1
//   start a new tile and clear done_pool on that accept edge.
//  Simultaneous: accept of column 0 of a new window in the same cycle the prior window output is
//   registered is legal; no bubble; back-to-back tiles sustain 1 column/cycle.
//  enable_pool falling mid-tile: partial window discarded, counters cleared, bypass begins next edge.
//  Reset mid-tile: async clear; first valid column after release is column 0 of a new tile.
// TESTING
//  1 k=2 max, all mask=1, lane i col c = (i+c)-16 -> 16 outputs, group g lane = 2g+c1-16+1
//   (col pair max), lanes 16..31 = 0, pulses 2 cycles after cols 1,3,..,31.
//  2 k=4 avg, all inputs 8'h05 except one 8'h0D per window -> sum 88, (88+8)>>>4 = 6; 8 outputs.
//  3 k=4 avg, 16 values of 8'hF8 (-1.0) and rounding case sum=-8 -> (-8+8)>>>4 = 0; -24 -> -1.
//  4 k=2 max, validity_mask=32'h0000FFFF, negative inputs -> groups 8..15 read 8'h80.
//  5 enable_pool=0 -> out_data equals inp_data one cycle later, done_pool=1 constantly.
//  6 k=2, in_data_available gaps every 3rd cycle, reset_n pulsed low after col 9 -> outputs 0
//   immediately; restart tile yields 16 correct outputs and done_pool after last.

Source files
------------

// File: rtl/pool.sv
// Pooling stage between normalization and activation: k x k max/average
// pooling over a DESIGN_SIZE-lane column stream, with a registered bypass.
module pool #(
    parameter int unsigned DWIDTH        = 8,
    parameter int unsigned DESIGN_SIZE   = 32,
    parameter int unsigned MAX_BITS_POOL = 3,
    parameter int unsigned ACC_WIDTH     = 12
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable_pool,
    input  logic                            pool_mode,
    input  logic [MAX_BITS_POOL-1:0]        pool_window_size,
    input  logic                            in_data_available,
    input  logic [DESIGN_SIZE*DWIDTH-1:0]   inp_data,
    input  logic [DESIGN_SIZE-1:0]          validity_mask,
    output logic [DESIGN_SIZE*DWIDTH-1:0]   out_data,
    output logic                            out_data_available,
    output logic                            done_pool
);

    localparam int unsigned CNT_W = $clog2(DESIGN_SIZE);

    // Window size stored as log2(k)
    localparam logic [1:0] K_1 = 2'd0;
    localparam logic [1:0] K_2 = 2'd1;
    localparam logic [1:0] K_4 = 2'd2;

    // Most negative element value, sign-extended to accumulator width
    localparam logic signed [ACC_WIDTH-1:0] MIN_VAL =
        $signed({{(ACC_WIDTH-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}});
    localparam logic signed [ACC_WIDTH-1:0] RND_2 = ACC_WIDTH'(2);
    localparam logic signed [ACC_WIDTH-1:0] RND_4 = ACC_WIDTH'(8);

    // Combine two partial results: add for average, signed max otherwise
    function automatic logic signed [ACC_WIDTH-1:0] fold(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [ACC_WIDTH-1:0] b,
        input logic                        is_avg
    );
        if (is_avg)
            return a + b;
        else
            return (a > b) ? a : b;
    endfunction

    // Tile/window bookkeeping and latched configuration
    logic [CNT_W-1:0] tile_cnt_q;
    logic [1:0]       win_cnt_q;
    logic [1:0]       cfg_k_q;
    logic             cfg_mode_q;

    // Stage 1: per-column group reduction
    logic signed [ACC_WIDTH-1:0] s1_q [DESIGN_SIZE];
    logic                        s1_valid_q;
    logic                        s1_first_q;
    logic                        s1_wlast_q;
    logic                        s1_tlast_q;
    logic [1:0]                  s1_k_q;
    logic                        s1_mode_q;

    // Stage 2: per-group window accumulators
    logic signed [ACC_WIDTH-1:0] acc_q [DESIGN_SIZE];
    logic                        acc_full_q;
    logic                        acc_tlast_q;
    logic [1:0]                  acc_k_q;
    logic                        acc_mode_q;

    logic                              accept_c;
    logic [1:0]                        k_in_c;
    logic [1:0]                        k_sel_c;
    logic                              mode_sel_c;
    logic [1:0]                        win_max_c;
    logic                              win_last_c;
    logic                              tile_last_c;
    logic signed [ACC_WIDTH-1:0]       lv_c  [DESIGN_SIZE];
    logic signed [ACC_WIDTH-1:0]       red_c [DESIGN_SIZE];
    logic [DESIGN_SIZE*DWIDTH-1:0]     out_c;

    assign accept_c    = enable_pool & in_data_available;
    assign tile_last_c = (tile_cnt_q == CNT_W'(DESIGN_SIZE-1));
    assign win_last_c  = (win_cnt_q == win_max_c);

    // Decode k; unsupported sizes behave as k=1. Live inputs apply only at tile start.
    always_comb begin
        k_in_c = K_1;
        case (pool_window_size)
            MAX_BITS_POOL'(2): k_in_c = K_2;
            MAX_BITS_POOL'(4): k_in_c = K_4;
            default:           k_in_c = K_1;
        endcase
        k_sel_c    = (tile_cnt_q == '0) ? k_in_c    : cfg_k_q;
        mode_sel_c = (tile_cnt_q == '0) ? pool_mode : cfg_mode_q;
        case (k_sel_c)
            K_2:     win_max_c = 2'd1;
            K_4:     win_max_c = 2'd3;
            default: win_max_c = 2'd0;
        endcase
    end

    // Lane preparation: sign-extend, masked lanes become the neutral element
    always_comb begin
        for (int i = 0; i < int'(DESIGN_SIZE); i++) begin
            if (validity_mask[i])
                lv_c[i] = ACC_WIDTH'($signed(inp_data[i*DWIDTH +: DWIDTH]));
            else
                lv_c[i] = mode_sel_c ? '0 : MIN_VAL;
        end
    end

    // Reduce k adjacent lanes per group
    always_comb begin
        for (int g = 0; g < int'(DESIGN_SIZE); g++)
            red_c[g] = '0;
        case (k_sel_c)
            K_2: begin
                for (int g = 0; g < int'(DESIGN_SIZE/2); g++)
                    red_c[g] = fold(lv_c[2*g], lv_c[2*g+1], mode_sel_c);
            end
            K_4: begin
                for (int g = 0; g < int'(DESIGN_SIZE/4); g++)
                    red_c[g] = fold(fold(lv_c[4*g],   lv_c[4*g+1], mode_sel_c),
                                    fold(lv_c[4*g+2], lv_c[4*g+3], mode_sel_c),
                                    mode_sel_c);
            end
            default: begin
                for (int g = 0; g < int'(DESIGN_SIZE); g++)
                    red_c[g] = lv_c[g];
            end
        endcase
    end

    // Stage 1 register plus tile/window counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tile_cnt_q <= '0;
            win_cnt_q  <= '0;
            cfg_k_q    <= K_1;
            cfg_mode_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_wlast_q <= 1'b0;
            s1_tlast_q <= 1'b0;
            s1_k_q     <= K_1;
            s1_mode_q  <= 1'b0;
            for (int g = 0; g < int'(DESIGN_SIZE); g++)
                s1_q[g] <= '0;
        end else if (!enable_pool) begin
            tile_cnt_q <= '0;
            win_cnt_q  <= '0;
            cfg_k_q    <= K_1;
            cfg_mode_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_wlast_q <= 1'b0;
            s1_tlast_q <= 1'b0;
            s1_k_q     <= K_1;
            s1_mode_q  <= 1'b0;
            for (int g = 0; g < int'(DESIGN_SIZE); g++)
                s1_q[g] <= '0;
        end else begin
            s1_valid_q <= accept_c;
            if (accept_c) begin
                for (int g = 0; g < int'(DESIGN_SIZE); g++)
                    s1_q[g] <= red_c[g];
                s1_first_q <= (win_cnt_q == 2'd0);
                s1_wlast_q <= win_last_c;
                s1_tlast_q <= tile_last_c;
                s1_k_q     <= k_sel_c;
                s1_mode_q  <= mode_sel_c;
                cfg_k_q    <= k_sel_c;
                cfg_mode_q <= mode_sel_c;
                win_cnt_q  <= win_last_c  ? 2'd0 : win_cnt_q + 2'd1;
                tile_cnt_q <= tile_last_c ? '0   : tile_cnt_q + CNT_W'(1);
            end
        end
    end

    // Stage 2: load on first column of a window, fold the rest
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_full_q  <= 1'b0;
            acc_tlast_q <= 1'b0;
            acc_k_q     <= K_1;
            acc_mode_q  <= 1'b0;
            for (int g = 0; g < int'(DESIGN_SIZE); g++)
                acc_q[g] <= '0;
        end else if (!enable_pool) begin
            acc_full_q  <= 1'b0;
            acc_tlast_q <= 1'b0;
            acc_k_q     <= K_1;
            acc_mode_q  <= 1'b0;
            for (int g = 0; g < int'(DESIGN_SIZE); g++)
                acc_q[g] <= '0;
        end else begin
            acc_full_q  <= s1_valid_q & s1_wlast_q;
            acc_tlast_q <= s1_valid_q & s1_wlast_q & s1_tlast_q;
            if (s1_valid_q) begin
                acc_k_q    <= s1_k_q;
                acc_mode_q <= s1_mode_q;
                for (int g = 0; g < int'(DESIGN_SIZE); g++)
                    acc_q[g] <= s1_first_q ? s1_q[g] : fold(acc_q[g], s1_q[g], s1_mode_q);
            end
        end
    end

    // Output formatting: average rounds half up via bias + arithmetic shift
    always_comb begin
        logic signed [ACC_WIDTH-1:0] biased;
        logic signed [ACC_WIDTH-1:0] val;
        int unsigned                 n_grp;
        biased = '0;
        val    = '0;
        n_grp  = DESIGN_SIZE >> acc_k_q;
        out_c  = '0;
        for (int g = 0; g < int'(DESIGN_SIZE); g++) begin
            case (acc_k_q)
                K_2: begin
                    biased = acc_q[g] + RND_2;
                    val    = biased >>> 2;
                end
                K_4: begin
                    biased = acc_q[g] + RND_4;
                    val    = biased >>> 4;
                end
                default: begin
                    biased = acc_q[g];
                    val    = acc_q[g];
                end
            endcase
            if (!acc_mode_q)
                val = acc_q[g];
            if (g < int'(n_grp))
                out_c[g*DWIDTH +: DWIDTH] = val[DWIDTH-1:0];
        end
    end

    // Output register, bypass path and sticky tile-done flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data           <= '0;
            out_data_available <= 1'b0;
            done_pool          <= 1'b0;
        end else if (!enable_pool) begin
            out_data           <= inp_data;
            out_data_available <= in_data_available;
            done_pool          <= 1'b1;
        end else begin
            out_data_available <= acc_full_q;
            if (acc_full_q)
                out_data <= out_c;
            if (acc_full_q && acc_tlast_q)
                done_pool <= 1'b1;
            else if (accept_c && done_pool)
                done_pool <= 1'b0;
        end
    end

endmodule
